// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline stage registers: control-bundle
// bit positions, default widths and the skid-entry state encoding.
package riscv_pipe_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    localparam int unsigned CTRL_MEM_WRITE  = 4;
    localparam int unsigned CTRL_REG_WRITE  = 3;
    localparam int unsigned CTRL_MEM_TO_REG = 2;
    localparam int unsigned CTRL_REG_SRC_HI = 1;
    localparam int unsigned CTRL_REG_SRC_LO = 0;

    localparam logic [1:0] SKID_EMPTY = 2'b00;
    localparam logic [1:0] SKID_ONE   = 2'b01;
    localparam logic [1:0] SKID_FULL  = 2'b11;

endpackage

// File: rtl/pipe_payload_reg.sv
// Enabled, reset-to-zero payload register of configurable width.
module pipe_payload_reg #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush-to-bubble and
// an optional registered-ready skid entry enabled by PIPE_STAGE_SKID_EN.
module pipe_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned N_DATA = 3,
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned DST_W  = REG_IDX_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [DST_W-1:0]         in_dst,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [DST_W-1:0]         out_dst,
    output logic [N_DATA*DATA_W-1:0] out_data
);

    localparam int unsigned PAY_W = DST_W + N_DATA * DATA_W;

    logic              xfer_in;
    logic              xfer_out;
    logic              main_valid;
    logic              main_load;
    logic [PAY_W-1:0]  main_d;
    logic [PAY_W-1:0]  main_q;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [CTRL_W-1:0] main_ctrl;

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              skid_load;
    logic [PAY_W-1:0]  skid_q;
    logic [CTRL_W-1:0] skid_ctrl;

    // Ready depends only on the state register, never on out_ready.
    assign in_ready   = (state != SKID_FULL);
    assign main_valid = (state != SKID_EMPTY);

    always_comb begin
        state_nxt   = state;
        main_load   = 1'b0;
        skid_load   = 1'b0;
        main_d      = {in_dst, in_data};
        main_ctrl_d = in_ctrl;
        if (flush) begin
            state_nxt = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (xfer_in) begin
                        state_nxt = SKID_ONE;
                        main_load = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_load = 1'b1;
                    end else if (xfer_in) begin
                        state_nxt = SKID_FULL;
                        skid_load = 1'b1;
                    end else if (xfer_out) begin
                        state_nxt = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (xfer_out) begin
                        state_nxt   = SKID_ONE;
                        main_load   = 1'b1;
                        main_d      = skid_q;
                        main_ctrl_d = skid_ctrl;
                    end
                end
                default: state_nxt = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            skid_ctrl <= '0;
        end else if (flush) begin
            skid_ctrl <= '0;
        end else if (skid_load) begin
            skid_ctrl <= in_ctrl;
        end
    end

    pipe_payload_reg #(.W(PAY_W)) u_skid (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (skid_load),
        .d     ({in_dst, in_data}),
        .q     (skid_q)
    );
`else
    assign in_ready    = out_ready || !main_valid;
    assign main_load   = xfer_in && !flush;
    assign main_d      = {in_dst, in_data};
    assign main_ctrl_d = in_ctrl;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            main_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (xfer_in) begin
            main_valid <= 1'b1;
        end else if (xfer_out) begin
            main_valid <= 1'b0;
        end
    end
`endif

    // Ctrl is cleared by flush; dst/data deliberately keep stale contents.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            main_ctrl <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
        end else if (main_load) begin
            main_ctrl <= main_ctrl_d;
        end
    end

    pipe_payload_reg #(.W(PAY_W)) u_main (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    assign out_valid           = main_valid;
    assign out_ctrl            = main_valid ? main_ctrl : '0;
    assign {out_dst, out_data} = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based occupancy model plus
// directed literal checks and randomized traffic (honours PIPE_STAGE_SKID_EN).
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_DATA = 3;
    localparam int unsigned CTRL_W = 5;
    localparam int unsigned DST_W  = 5;
    localparam int unsigned DW     = N_DATA * DATA_W;
`ifdef PIPE_STAGE_SKID_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif

    logic              CLK;
    logic              RESET;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DST_W-1:0]  in_dst;
    logic [DW-1:0]     in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DST_W-1:0]  out_dst;
    logic [DW-1:0]     out_data;

    int total = 0;
    int bad   = 0;
    logic last_acc = 1'b0;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .N_DATA (N_DATA),
        .CTRL_W (CTRL_W),
        .DST_W  (DST_W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_dst    (in_dst),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_dst   (out_dst),
        .out_data  (out_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of capacity DEPTH; the visible payload is
    // the head, or the last head shown once the FIFO empties.
    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DST_W-1:0]  d;
        logic [DW-1:0]     x;
    } pl_t;

    pl_t q[$];
    pl_t shown = '0;

    always @(negedge CLK) begin : cmp
        logic ev, er, xin, xout;
        if (!RESET) begin
            q.delete();
            shown = '0;
        end
        ev = (q.size() != 0);
`ifdef PIPE_STAGE_SKID_EN
        er = (q.size() < DEPTH);
`else
        er = out_ready || !ev;
`endif
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, er);
        chk("out_ctrl", out_ctrl, ev ? q[0].c : '0);
        chk("out_dst", out_dst, shown.d);
        chk("out_data", out_data, shown.x);
        if (RESET) begin
            xin  = in_valid && er;
            xout = ev && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (xout) void'(q.pop_front());
                if (xin) q.push_back({in_ctrl, in_dst, in_data});
            end
            if (q.size() != 0) shown = q[0];
        end
    end

    task automatic step();
        #1 last_acc = in_valid && in_ready;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc;
        int pid;
        RESET     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_dst    = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, '0);
        RESET = 1'b1;

        // Streaming: PCs in field 0, one per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 5'h08;
            in_dst   = 5'(i + 1);
            in_data  = {64'h0, 32'h100 + 32'(4 * i)};
            step();
            chk("stream_pc", out_data[31:0], 32'h100 + 32'(4 * i));
            chk("stream_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", out_valid, 1'b0);

        // Back-pressure with upstream holding unaccepted payloads.
        out_ready = 1'b0;
        acc = 0;
        pid = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0 || last_acc) begin
                in_valid = 1'b1;
                in_ctrl  = 5'(pid + 1);
                in_dst   = 5'(pid + 9);
                in_data  = {64'h1234, 32'hA000 + 32'(pid)};
                pid++;
            end
            step();
            if (last_acc) acc++;
        end
        chk("bp_accepted", acc, DEPTH);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_hold", out_data[31:0], 32'hA000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
`ifdef PIPE_STAGE_SKID_EN
        chk("drain_b", out_data[31:0], 32'hA001);
        chk("drain_b_valid", out_valid, 1'b1);
        chk("drain_rdy", in_ready, 1'b1);
        step();
`endif
        chk("drain_empty", out_valid, 1'b0);

        // Flush with a concurrent incoming instruction.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 5'h08;
        in_dst    = 5'h07;
        in_data   = {64'h55, 32'hBEEF};
        step();
        chk("flush_held_ctrl", out_ctrl, 5'h08);
        in_ctrl = 5'h1F;
        in_data = {64'h66, 32'hDEAD};
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ctrl", out_ctrl, 5'h00);
        chk("flush_rdy", in_ready, 1'b1);
        chk("flush_stale", out_data[31:0], 32'hBEEF);
        step();
        chk("bubble_valid", out_valid, 1'b0);
        chk("bubble_ctrl", out_ctrl, 5'h00);

        // Asynchronous reset while holding a valid instruction.
        in_valid = 1'b1;
        in_ctrl  = 5'h1F;
        in_dst   = 5'h15;
        in_data  = {64'h77, 32'hCAFE};
        step();
        chk("pre_rst_ctrl", out_ctrl, 5'h1F);
        in_valid = 1'b0;
        #2 RESET = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ctrl", out_ctrl, 5'h00);
        chk("arst_dst", out_dst, 5'h00);
        chk("arst_data", out_data, '0);
        chk("arst_rdy", in_ready, 1'b1);
        @(posedge CLK);
        #1 RESET = 1'b1;
        last_acc = 1'b0;

        // Random traffic; upstream keeps an unaccepted payload stable.
        for (int c = 0; c < 400; c++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_ctrl  = 5'($urandom_range(0, 31));
                in_dst   = 5'($urandom_range(0, 31));
                in_data  = {$urandom, $urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
